// File: rtl/serial_add_sub.sv
// Multi-cycle adder/subtractor: resolves BITS_PER_CYCLE bits per clock, LSB
// first, through a chain of full-adder slices with a registered carry.
// Subtract is performed as A + ~B + ~Cin, so Cout=1 means "no borrow".

// One full-adder cell of the per-step slice.
module serial_add_sub_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_add_sub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             Ovf
);
  localparam int BPC   = BITS_PER_CYCLE;
  localparam int STEPS = WIDTH / BPC;
  localparam int CW    = $clog2(STEPS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_nxt;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [BPC:0]     c_chain;
  logic [BPC-1:0]   sum_slice;
  logic             accept, last;

  // A new request is taken whenever no computation is in flight (IDLE or DONE).
  assign accept = start && (state != RUN);
  assign last   = (state == RUN) && (cnt == CW'(1));

  // Carry ripples through the slice, seeded by the registered carry.
  assign c_chain[0] = carry;
  for (genvar i = 0; i < BPC; i++) begin : g_fa
    serial_add_sub_fa u_fa (
      .a  (a_sh[i]),
      .b  (b_sh[i]),
      .ci (c_chain[i]),
      .s  (sum_slice[i]),
      .co (c_chain[i+1])
    );
  end

  // Slice sum enters from the MSB end; after STEPS shifts it is in place.
  assign res_nxt = (res_sh >> BPC) | (WIDTH'(sum_slice) << (WIDTH - BPC));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode directly from the state.
  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Datapath: operand load, per-step shift/add, result capture on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      S      <= '0;
      Cout   <= 1'b0;
      Ovf    <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B ^ {WIDTH{Sub}};
      carry <= Cin ^ Sub;
      cnt   <= CW'(STEPS);
    end else if (state == RUN) begin
      a_sh   <= a_sh >> BPC;
      b_sh   <= b_sh >> BPC;
      res_sh <= res_nxt;
      carry  <= c_chain[BPC];
      cnt    <= cnt - CW'(1);
      if (last) begin
        S    <= res_nxt;
        Cout <= c_chain[BPC];
        // Top cell of the last slice is the MSB: carry in vs carry out.
        Ovf  <= c_chain[BPC] ^ c_chain[BPC-1];
      end
    end
  end
endmodule

// File: tb/tb_serial_add_sub.sv
// Directed bench for serial_add_sub in three configurations:
// 8-bit/1 bit per cycle, 4-bit/2 bits per cycle, and 1-bit.
module tb_serial_add_sub;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8, BPC=1
  logic       st8 = 0, ci8 = 0, sb8 = 0, bz8, dn8, co8, ov8;
  logic [7:0] a8 = 0, b8 = 0, s8;
  // WIDTH=4, BPC=2
  logic       st4 = 0, ci4 = 0, sb4 = 0, bz4, dn4, co4, ov4;
  logic [3:0] a4 = 0, b4 = 0, s4;
  // WIDTH=1, BPC=1
  logic       st1 = 0, ci1 = 0, sb1 = 0, bz1, dn1, co1, ov1;
  logic [0:0] a1 = 0, b1 = 0, s1;

  serial_add_sub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut8 (
    .clk(clk), .rst(rst), .start(st8), .A(a8), .B(b8), .Cin(ci8), .Sub(sb8),
    .busy(bz8), .done(dn8), .S(s8), .Cout(co8), .Ovf(ov8));
  serial_add_sub #(.WIDTH(4), .BITS_PER_CYCLE(2)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .A(a4), .B(b4), .Cin(ci4), .Sub(sb4),
    .busy(bz4), .done(dn4), .S(s4), .Cout(co4), .Ovf(ov4));
  serial_add_sub #(.WIDTH(1), .BITS_PER_CYCLE(1)) dut1 (
    .clk(clk), .rst(rst), .start(st1), .A(a1), .B(b1), .Cin(ci1), .Sub(sb1),
    .busy(bz1), .done(dn1), .S(s1), .Cout(co1), .Ovf(ov1));

  // Launch one 8-bit op; return edges from accept to done and busy cycles.
  task automatic go8(input logic [7:0] a, b, input logic c, s,
                     output int cyc, output int bcnt);
    @(negedge clk); a8 = a; b8 = b; ci8 = c; sb8 = s; st8 = 1;
    @(negedge clk); st8 = 0; cyc = 0; bcnt = 0;
    while (dn8 !== 1'b1 && cyc < 40) begin
      if (bz8) bcnt++;
      @(negedge clk); cyc++;
    end
  endtask

  task automatic go4(input logic [3:0] a, b, input logic c, s, output int cyc);
    @(negedge clk); a4 = a; b4 = b; ci4 = c; sb4 = s; st4 = 1;
    @(negedge clk); st4 = 0; cyc = 0;
    while (dn4 !== 1'b1 && cyc < 40) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic go1(input logic a, b, c, output int cyc);
    @(negedge clk); a1 = a; b1 = b; ci1 = c; sb1 = 0; st1 = 1;
    @(negedge clk); st1 = 0; cyc = 0;
    while (dn1 !== 1'b1 && cyc < 40) begin
      @(negedge clk); cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bz8, dn8, s8, co8, ov8} !== 12'h0) begin
      errors++;
      $display("FAIL reset8 got busy=%b done=%b S=%h Cout=%b Ovf=%b want all 0",
               bz8, dn8, s8, co8, ov8);
    end
    checks++;
    if ({bz4, dn4, s4, co4, ov4} !== 8'h0) begin
      errors++;
      $display("FAIL reset4 got busy=%b done=%b S=%h Cout=%b Ovf=%b want all 0",
               bz4, dn4, s4, co4, ov4);
    end
    rst = 0;
  endtask

  task automatic test_add();
    int cyc, bcnt;
    go8(8'h5A, 8'h3C, 0, 0, cyc, bcnt);
    checks++;
    if ({s8, co8, ov8} !== {8'h96, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL add S/Cout/Ovf got %h/%b/%b want 96/0/1", s8, co8, ov8);
    end
    checks++;
    if (cyc != 8) begin
      errors++; $display("FAIL add_latency got %0d want 8", cyc);
    end
    checks++;
    if (bcnt != 8) begin
      errors++; $display("FAIL add_busy_cycles got %0d want 8", bcnt);
    end
    @(negedge clk);
    checks++;
    if (dn8 !== 1'b0 || bz8 !== 1'b0) begin
      errors++; $display("FAIL add_done_pulse got done=%b busy=%b want 0/0", dn8, bz8);
    end
  endtask

  // Wrap-around add, then a borrowing subtract accepted in the DONE cycle.
  task automatic test_back_to_back();
    int cyc, bcnt;
    go8(8'hFF, 8'h01, 1, 0, cyc, bcnt);
    checks++;
    if ({s8, co8, ov8} !== {8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL wrap S/Cout/Ovf got %h/%b/%b want 01/1/0", s8, co8, ov8);
    end
    a8 = 8'h10; b8 = 8'h20; ci8 = 0; sb8 = 1; st8 = 1;
    @(negedge clk); st8 = 0; a8 = 8'hAA; b8 = 8'h55;
    checks++;
    if (bz8 !== 1'b1 || dn8 !== 1'b0) begin
      errors++; $display("FAIL b2b_no_gap got busy=%b done=%b want 1/0", bz8, dn8);
    end
    checks++;
    if ({s8, co8, ov8} !== {8'h01, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL b2b_hold S/Cout/Ovf got %h/%b/%b want 01/1/0", s8, co8, ov8);
    end
    cyc = 0;
    while (dn8 !== 1'b1 && cyc < 40) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc != 8) begin
      errors++; $display("FAIL b2b_latency got %0d want 8", cyc);
    end
    checks++;
    if ({s8, co8, ov8} !== {8'hF0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL sub_borrow S/Cout/Ovf got %h/%b/%b want f0/0/0", s8, co8, ov8);
    end
  endtask

  task automatic test_sub_ovf();
    int cyc, bcnt;
    go8(8'h80, 8'h01, 0, 1, cyc, bcnt);
    checks++;
    if ({s8, co8, ov8} !== {8'h7F, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sub_ovf S/Cout/Ovf got %h/%b/%b want 7f/1/1", s8, co8, ov8);
    end
  endtask

  task automatic test_ignore_start();
    int cyc;
    @(negedge clk); a8 = 8'h5A; b8 = 8'h3C; ci8 = 0; sb8 = 0; st8 = 1;
    @(negedge clk); st8 = 0; cyc = 0;
    repeat (2) begin @(negedge clk); cyc++; end
    a8 = 8'h01; b8 = 8'h01; sb8 = 1; ci8 = 1; st8 = 1;
    @(negedge clk); cyc++; st8 = 0; a8 = 8'hFF;
    while (dn8 !== 1'b1 && cyc < 40) begin
      @(negedge clk); cyc++;
    end
    checks++;
    if ({s8, co8, ov8} !== {8'h96, 1'b0, 1'b1} || cyc != 8) begin
      errors++;
      $display("FAIL ignore_start got S=%h Cout=%b Ovf=%b lat=%0d want 96/0/1 lat 8",
               s8, co8, ov8, cyc);
    end
    @(negedge clk);
    checks++;
    if (bz8 !== 1'b0 || dn8 !== 1'b0) begin
      errors++; $display("FAIL ignore_no_queue got busy=%b done=%b want 0/0", bz8, dn8);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    @(negedge clk); a8 = 8'h80; b8 = 8'h01; ci8 = 0; sb8 = 1; st8 = 1;
    @(negedge clk); st8 = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    checks++;
    if ({bz8, dn8, s8, co8, ov8} !== 12'h0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b done=%b S=%h Cout=%b Ovf=%b want all 0",
               bz8, dn8, s8, co8, ov8);
    end
    rst = 0;
    repeat (12) begin
      @(negedge clk);
      if (dn8 === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || bz8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_no_done got pulses=%0d busy=%b want 0/0", pulses, bz8);
    end
  endtask

  task automatic test_sweep_w4();
    int cyc;
    logic [3:0] bb, es;
    logic [4:0] full;
    logic       cc, eov;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++) begin
            bb   = (s != 0) ? ~4'(b) : 4'(b);
            cc   = 1'(c) ^ 1'(s);
            full = {1'b0, 4'(a)} + {1'b0, bb} + {4'b0, cc};
            es   = full[3:0];
            eov  = (a[3] == bb[3]) && (es[3] != a[3]);
            go4(4'(a), 4'(b), 1'(c), 1'(s), cyc);
            checks++;
            if ({s4, co4, ov4} !== {es, full[4], eov} || cyc != 2) begin
              errors++;
              $display("FAIL sweep4 A=%h B=%h Cin=%0d Sub=%0d got %h/%b/%b lat=%0d want %h/%b/%b lat 2",
                       a, b, c, s, s4, co4, ov4, cyc, es, full[4], eov);
            end
          end
  endtask

  task automatic test_width1();
    int cyc;
    logic a, b, c, es, ec;
    for (int r = 0; r < 8; r++) begin
      a  = r[2]; b = r[1]; c = r[0];
      es = a ^ b ^ c;
      ec = (a & b) | (a & c) | (b & c);
      go1(a, b, c, cyc);
      checks++;
      if ({s1, co1, ov1} !== {es, ec, c ^ ec} || cyc != 1) begin
        errors++;
        $display("FAIL width1 row=%0d got %b/%b/%b lat=%0d want %b/%b/%b lat 1",
                 r, s1, co1, ov1, cyc, es, ec, c ^ ec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_sub_ovf();
    test_ignore_start();
    test_reset_mid();
    test_sweep_w4();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_sub.md
Name: serial_add_sub

Overview:
- Parametrised multi-cycle adder/subtractor built around a full-adder slice.
- Processes BITS_PER_CYCLE bits per clock, LSB first, with a registered carry between steps.
- A start/busy/done handshake lets one small datapath serve WIDTH-bit arithmetic.
- Supplies compact arithmetic to the combinational-design sub-blocks where area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; must be >= 1.
- BITS_PER_CYCLE, 1, bits resolved per clock; must be >= 1 and must divide WIDTH. STEPS = WIDTH / BITS_PER_CYCLE.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- A  input  WIDTH  operand A; sampled on the accept edge only.
- B  input  WIDTH  operand B; sampled on the accept edge only.
- Cin  input  1  carry-in (Sub=0) or borrow-in (Sub=1); sampled on the accept edge.
- Sub  input  1  0 computes A+B+Cin; 1 computes A-B-Cin. Sampled on the accept edge.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when the result is valid.
- S  output  WIDTH  result, low WIDTH bits.
- Cout  output  1  final carry; when Sub=1, Cout=1 means no borrow.
- Ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB).

Behaviour:
- Clock and reset: one clock (clk). Reset rst is synchronous and active-high.
- Reset state: state=IDLE; busy=0; done=0; S=0; Cout=0; Ovf=0; internal shift registers, carry and step counter cleared.
- Reset mid-operation: the computation is abandoned on the next edge and no done pulse is issued.
- States: IDLE, RUN, DONE.
- Accept: on an edge where start=1 and state is IDLE or DONE:
  - latch A;
  - latch B XOR {WIDTH{Sub}};
  - carry <= Cin XOR Sub (subtract is A + ~B + ~Cin);
  - step counter <= STEPS;
  - state -> RUN; busy=1 from the following cycle.
- RUN, each edge:
  - add the low BITS_PER_CYCLE bits of the operand registers with the carry via a chained full-adder slice;
  - shift the operand registers right by BITS_PER_CYCLE;
  - shift the slice sum into the result register from the MSB end;
  - update the carry and decrement the counter.
  - On the final step, capture the carry into the MSB for Ovf.
- Completion: after the STEPS-th RUN edge, state -> DONE, busy=0, done=1 for exactly one cycle.
  - S, Cout and Ovf are valid and held until the next accept edge or rst.
- Latency: the accept edge is t0 and processing edges are t0+1..t0+STEPS, so done is visible after edge t0+STEPS. With WIDTH=8, BITS_PER_CYCLE=1, that is 8 cycles after the accept edge.
- DONE: returns to IDLE on the next edge. If start=1 in DONE, a new operation is accepted instead (back-to-back; done still pulses only one cycle).
- start while busy=1: ignored. Operand inputs are don't-care during RUN; changing them has no effect.
- Outputs during RUN: S, Cout and Ovf keep the previous result; the partial sum is internal only.
- WIDTH=1, BITS_PER_CYCLE=1: behaves as a registered full adder/subtractor with 1-cycle processing.
- Arithmetic: all operations are modulo 2^WIDTH. No sign extension is performed; the caller interprets the result using Cout and Ovf.

Test Plan:
- Add, WIDTH=8, BPC=1: A=0x5A, B=0x3C, Cin=0, Sub=0 -> S=0x96, Cout=0, Ovf=1. done pulses once, 8 cycles after accept; busy high for exactly 8 cycles.
- Wrap-around: A=0xFF, B=0x01, Cin=1, Sub=0 -> S=0x01, Cout=1, Ovf=0.
- Subtract with borrow: A=0x10, B=0x20, Cin=0, Sub=1 -> S=0xF0, Cout=0, Ovf=0.
- Subtract overflow: A=0x80, B=0x01, Cin=0, Sub=1 -> S=0x7F, Cout=1, Ovf=1.
- Handshake and reset:
  - start re-pulsed during RUN with different operands -> ignored, first result unchanged;
  - start held in the DONE cycle -> second operation accepted with no idle gap;
  - rst asserted at step 4 -> all outputs 0 next cycle, no done pulse.
- Exhaustive sweep against a behavioural model:
  - WIDTH=4, BPC=2: all 2^10 combinations of A/B/Cin/Sub -> S, Cout and Ovf match, latency = 2 cycles after accept;
  - WIDTH=1: the 8-row full-adder truth table with Sub=0 matches.
